// File: rtl/serial_mult_pkg.sv
// Shared definitions for the segment-serial multiplier bridge.
//   state_t        : bridge FSM states (3-bit encoding)
//   beats_per_word : segment beats needed to carry one operand
//   cnt_w          : counter width able to hold 0..n-1 (never below 1 bit)
package serial_mult_pkg;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    MUL    = 3'd2,
    FIX    = 3'd3,
    OUT    = 3'd4
  } state_t;

  function automatic int beats_per_word(input int seg_w, input int word_w);
    return word_w / seg_w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_mult_bridge_shift_add_core.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : loads operands and clears the accumulator (restarts any run)
//   multiplicand : WORD_W-bit unsigned operand
//   multiplier   : WORD_W-bit unsigned operand
//   done         : high during the cycle whose edge adds the final bit
//   product      : 2*WORD_W-bit accumulator, final from the cycle after done
module shift_add_core
  import serial_mult_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_W-1:0]     multiplicand,
  input  logic [WORD_W-1:0]     multiplier,
  output logic                  done,
  output logic [2*WORD_W-1:0]   product
);

  localparam int CW = cnt_w(WORD_W);
  localparam logic [CW-1:0] BIT_LAST = CW'(WORD_W - 1);

  logic [2*WORD_W-1:0] mcand;
  logic [WORD_W-1:0]   mplier;
  logic [2*WORD_W-1:0] acc;
  logic [CW-1:0]       bit_cnt;
  logic                run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      run     <= 1'b0;
    end else if (start) begin
      mcand   <= {{WORD_W{1'b0}}, multiplicand};
      mplier  <= multiplier;
      acc     <= '0;
      bit_cnt <= '0;
      run     <= 1'b1;
    end else if (run) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      bit_cnt <= bit_cnt + 1'b1;
      if (bit_cnt == BIT_LAST) run <= 1'b0;
    end
  end

  // Combinational so the FSM can leave MUL on the same edge as the last add.
  assign done    = run && (bit_cnt == BIT_LAST);
  assign product = acc;

endmodule

// File: rtl/serial_mult_bridge.sv
// Segment-serial multiply bridge: receives A then B, SEG_W bits per beat (LS
// segment first), multiplies unsigned or two's-complement, streams the
// 2*WORD_W-bit product back LS segment first.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : synchronous abort back to LOAD_A
//   signed_mode         : 0 unsigned / 1 signed, captured with the first A beat
//   in_valid/in_seg/in_ready    : input segment handshake
//   out_valid/out_seg/out_ready : product segment handshake
//   busy                : high whenever not in LOAD_A
module serial_mult_bridge
  import serial_mult_pkg::*;
#(
  parameter int SEG_W  = 4,
  parameter int WORD_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             signed_mode,
  input  logic             in_valid,
  input  logic [SEG_W-1:0] in_seg,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SEG_W-1:0] out_seg,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NB = beats_per_word(SEG_W, WORD_W);
  localparam int IW = cnt_w(NB);
  localparam int OW = cnt_w(2 * NB);
  localparam logic [IW-1:0] IN_LAST  = IW'(NB - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(2 * NB - 1);

  state_t                state;
  logic [IW-1:0]         in_cnt;
  logic [OW-1:0]         out_cnt;
  logic [WORD_W-1:0]     a_reg;
  logic [WORD_W-1:0]     b_reg;
  logic [2*WORD_W-1:0]   p_reg;
  logic                  sgn;
  logic                  neg;
  logic                  start_q;
  logic                  core_done;
  logic [2*WORD_W-1:0]   core_prod;
  logic [2*WORD_W-1:0]   p_fix;
  logic                  in_xfer;
  logic                  out_xfer;

  // |x| in an unsigned register; -2^(W-1) maps to 2^(W-1), which still fits.
  function automatic logic [WORD_W-1:0] magnitude(input logic signed [WORD_W-1:0] x,
                                                  input logic s);
    return (s && (x < 0)) ? WORD_W'(-x) : WORD_W'(x);
  endfunction

  function automatic logic [2*WORD_W-1:0] negate(input logic signed [2*WORD_W-1:0] x);
    return (2*WORD_W)'(-x);
  endfunction

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign p_fix    = neg ? negate(core_prod) : core_prod;

  shift_add_core #(.WORD_W(WORD_W)) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_q),
    .multiplicand (magnitude(a_reg, sgn)),
    .multiplier   (magnitude(b_reg, sgn)),
    .done         (core_done),
    .product      (core_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      in_cnt    <= '0;
      out_cnt   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= '0;
      sgn       <= 1'b0;
      neg       <= 1'b0;
      start_q   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_seg   <= '0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= LOAD_A;
      in_cnt    <= '0;
      out_cnt   <= '0;
      start_q   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_seg   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            a_reg[SEG_W*int'(in_cnt) +: SEG_W] <= in_seg;
            if (in_cnt == '0) sgn <= signed_mode;
            if (in_cnt == IN_LAST) begin
              state  <= LOAD_B;
              in_cnt <= '0;
              busy   <= 1'b1;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (in_xfer) begin
            b_reg[SEG_W*int'(in_cnt) +: SEG_W] <= in_seg;
            if (in_cnt == IN_LAST) begin
              state    <= MUL;
              in_cnt   <= '0;
              in_ready <= 1'b0;
              start_q  <= 1'b1;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        MUL: begin
          // First MUL cycle: core loads magnitudes; result sign is captured
          // from the raw operands before they are overwritten.
          if (start_q) begin
            start_q <= 1'b0;
            neg     <= sgn && (a_reg[WORD_W-1] ^ b_reg[WORD_W-1]);
            a_reg   <= magnitude(a_reg, sgn);
            b_reg   <= magnitude(b_reg, sgn);
          end else if (core_done) begin
            state <= FIX;
          end
        end
        FIX: begin
          p_reg     <= p_fix;
          out_seg   <= p_fix[SEG_W-1:0];
          out_cnt   <= '0;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_xfer) begin
            if (out_cnt == OUT_LAST) begin
              state     <= LOAD_A;
              out_cnt   <= '0;
              out_valid <= 1'b0;
              out_seg   <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_cnt <= out_cnt + 1'b1;
              out_seg <= p_reg[SEG_W*(int'(out_cnt) + 1) +: SEG_W];
            end
          end
        end
        default: begin
          state <= LOAD_A;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
